// File: rtl/nxu8_burst_bridge_if.sv
// Bundle of the uart_rx / uart_tx / nxu8_serdes facing signals of the burst bridge.
// Signal names are kept as seen from the bridge; "master" is the bridge side,
// "slave" is the environment (uart peers and serdes).
interface nxu8_burst_bridge_if #(
    parameter int DATA_BYTES = 2
);
    localparam int DW = 8 * DATA_BYTES;

    logic [7:0]    i_rx_data;
    logic          i_rx_rdy;
    logic          o_rx_ack;
    logic [7:0]    o_tx_data;
    logic          o_tx_start;
    logic          i_tx_busy;
    logic          o_nx_start;
    logic [6:0]    o_nx_addr;
    logic          o_nx_wr;
    logic [DW-1:0] o_nx_wdata;
    logic [DW-1:0] i_nx_rdata;
    logic          i_nx_busy;
    logic          o_active;

    modport master (
        input  i_rx_data, i_rx_rdy, i_tx_busy, i_nx_rdata, i_nx_busy,
        output o_rx_ack, o_tx_data, o_tx_start, o_nx_start, o_nx_addr,
               o_nx_wr, o_nx_wdata, o_active
    );

    modport slave (
        output i_rx_data, i_rx_rdy, i_tx_busy, i_nx_rdata, i_nx_busy,
        input  o_rx_ack, o_tx_data, o_tx_start, o_nx_start, o_nx_addr,
               o_nx_wr, o_nx_wdata, o_active
    );
endinterface

// File: rtl/nxu8_burst_bridge.sv
// UART <-> nX-U8 serdes burst bridge.
// Decodes a 2-byte header {W,addr} {INC,LEN-1} and runs 1..128 register
// reads or writes of DATA_BYTES-wide words, MSB byte first on the wire.
// Optional inter-byte timeout: define BRIDGE_TIMEOUT_EN.
module nxu8_burst_bridge #(
    parameter int DATA_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input logic                 i_clk,
    input logic                 i_rst,
    nxu8_burst_bridge_if.master bus
);
    localparam int         DW        = 8 * DATA_BYTES;
    localparam logic [2:0] LAST_BYTE = 3'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_CMD, S_LEN, S_WDATA, S_WISSUE, S_WWAIT, S_RISSUE, S_RWAIT, S_RSEND
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_wr_cmd, w_wr_cmd_nxt;
    logic          r_inc, w_inc_nxt;
    logic [6:0]    r_addr, w_addr_nxt;
    logic [6:0]    r_count, w_count_nxt;
    logic [2:0]    r_byte_idx, w_byte_idx_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic [DW-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [7:0]    r_tx_data, w_tx_data_nxt;
    logic          r_rx_ack, w_rx_ack_nxt, r_rx_guard;
    logic          r_tx_start, w_tx_start_nxt, r_tx_guard;
    logic          r_nx_start, w_nx_start_nxt, r_nx_guard;
    logic          r_nx_wr, w_nx_wr_nxt;
    logic          w_rx_ok, w_tx_free, w_nx_free;
    logic          w_to_expired;

    // Peer flags are ignored while our pulse is high and for one cycle after,
    // since the peer needs a cycle to reflect the pulse in its flag.
    assign w_rx_ok   = bus.i_rx_rdy && !r_rx_ack && !r_rx_guard;
    assign w_tx_free = !bus.i_tx_busy && !r_tx_start && !r_tx_guard;
    assign w_nx_free = !bus.i_nx_busy && !r_nx_start && !r_nx_guard;

`ifdef BRIDGE_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    // Inter-byte timer: runs only while header or write payload bytes are awaited
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (w_rx_ack_nxt || !(r_state == S_LEN || r_state == S_WDATA)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    assign w_to_expired = (r_to_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
    // Timer compiled out: never expires
    assign w_to_expired = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and next-output decode; a received byte beats a coinciding timeout
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_cmd_nxt   = r_wr_cmd;
        w_inc_nxt      = r_inc;
        w_addr_nxt     = r_addr;
        w_count_nxt    = r_count;
        w_byte_idx_nxt = r_byte_idx;
        w_wdata_nxt    = r_wdata;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_data_nxt  = r_tx_data;
        w_nx_wr_nxt    = r_nx_wr;
        w_rx_ack_nxt   = 1'b0;
        w_tx_start_nxt = 1'b0;
        w_nx_start_nxt = 1'b0;
        unique case (r_state)
            S_CMD: begin
                if (w_rx_ok) begin
                    w_rx_ack_nxt = 1'b1;
                    w_wr_cmd_nxt = bus.i_rx_data[7];
                    w_addr_nxt   = bus.i_rx_data[6:0];
                    w_state_nxt  = S_LEN;
                end
            end
            S_LEN: begin
                if (w_rx_ok) begin
                    w_rx_ack_nxt   = 1'b1;
                    w_inc_nxt      = bus.i_rx_data[7];
                    w_count_nxt    = bus.i_rx_data[6:0];
                    w_byte_idx_nxt = '0;
                    w_state_nxt    = r_wr_cmd ? S_WDATA : S_RISSUE;
                end else if (w_to_expired) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_WDATA: begin
                if (w_rx_ok) begin
                    w_rx_ack_nxt = 1'b1;
                    w_wdata_nxt  = (r_wdata << 8) | DW'(bus.i_rx_data);
                    if (r_byte_idx == LAST_BYTE) begin
                        w_byte_idx_nxt = '0;
                        w_state_nxt    = S_WISSUE;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 3'd1;
                    end
                end else if (w_to_expired) begin
                    w_byte_idx_nxt = '0;
                    w_state_nxt    = S_CMD;
                end
            end
            S_WISSUE: begin
                if (w_nx_free) begin
                    w_nx_start_nxt = 1'b1;
                    w_nx_wr_nxt    = 1'b1;
                    w_state_nxt    = S_WWAIT;
                end
            end
            S_WWAIT: begin
                if (w_nx_free) begin
                    if (r_count == 7'd0) begin
                        w_state_nxt = S_CMD;
                    end else begin
                        w_count_nxt = r_count - 7'd1;
                        w_addr_nxt  = r_addr + {6'd0, r_inc};
                        w_state_nxt = S_WDATA;
                    end
                end
            end
            S_RISSUE: begin
                if (w_nx_free) begin
                    w_nx_start_nxt = 1'b1;
                    w_nx_wr_nxt    = 1'b0;
                    w_state_nxt    = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (w_nx_free) begin
                    w_tx_shift_nxt = bus.i_nx_rdata;
                    w_byte_idx_nxt = '0;
                    w_state_nxt    = S_RSEND;
                end
            end
            S_RSEND: begin
                if (w_tx_free) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = r_tx_shift[DW-1 -: 8];
                    w_tx_shift_nxt = r_tx_shift << 8;
                    if (r_byte_idx == LAST_BYTE) begin
                        w_byte_idx_nxt = '0;
                        if (r_count == 7'd0) begin
                            w_state_nxt = S_CMD;
                        end else begin
                            w_count_nxt = r_count - 7'd1;
                            w_addr_nxt  = r_addr + {6'd0, r_inc};
                            w_state_nxt = S_RISSUE;
                        end
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 3'd1;
                    end
                end
            end
            default: w_state_nxt = S_CMD;
        endcase
    end

    // State, datapath and registered output pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_CMD;
            r_wr_cmd   <= 1'b0;
            r_inc      <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_wdata    <= '0;
            r_tx_shift <= '0;
            r_tx_data  <= '0;
            r_nx_wr    <= 1'b0;
            r_rx_ack   <= 1'b0;
            r_tx_start <= 1'b0;
            r_nx_start <= 1'b0;
            r_rx_guard <= 1'b0;
            r_tx_guard <= 1'b0;
            r_nx_guard <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_cmd   <= w_wr_cmd_nxt;
            r_inc      <= w_inc_nxt;
            r_addr     <= w_addr_nxt;
            r_count    <= w_count_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_wdata    <= w_wdata_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_nx_wr    <= w_nx_wr_nxt;
            r_rx_ack   <= w_rx_ack_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_nx_start <= w_nx_start_nxt;
            r_rx_guard <= r_rx_ack;
            r_tx_guard <= r_tx_start;
            r_nx_guard <= r_nx_start;
        end
    end

    assign bus.o_rx_ack   = r_rx_ack;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = r_tx_start;
    assign bus.o_nx_start = r_nx_start;
    assign bus.o_nx_addr  = r_addr;
    assign bus.o_nx_wr    = r_nx_wr;
    assign bus.o_nx_wdata = r_wdata;
    assign bus.o_active   = (r_state != S_CMD);
endmodule

// File: tb/tb_nxu8_burst_bridge.sv
// Bench for nxu8_burst_bridge: uart/serdes peer models, a command-level
// reference model (register image + expected transaction/byte queues) and
// a per-cycle compare process on the falling edge.
module tb_nxu8_burst_bridge;
    localparam int DB = 2;
    localparam int DW = 8 * DB;
    localparam int TO = 100;
    localparam int SEL_TX = 0, SEL_NX = 1, SEL_ACK = 2;

    typedef struct packed {
        logic [6:0]    addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } nx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nxu8_burst_bridge_if #(.DATA_BYTES(DB)) bus ();

    nxu8_burst_bridge #(.DATA_BYTES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    logic [DW-1:0] sd_mem  [128];
    logic [DW-1:0] ref_mem [128];
    logic [7:0]    rx_q    [$];
    nx_t           exp_nx  [$];
    logic [7:0]    exp_tx  [$];
    logic [6:0]    log_addr[$];
    logic [7:0]    log_tx  [$];
    int unsigned   ack_cyc [$];
    int unsigned   nx_cyc  [$];

    logic force_tx = 1'b0;
    logic force_nx = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Peer models and scoreboard compare, all on the falling edge
    int unsigned nx_busy_cnt = 0, tx_busy_cnt = 0, rx_gap = 0;
    logic        rx_drop = 1'b0;
    nx_t         e;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bus.i_rx_rdy   = 1'b0;
            bus.i_rx_data  = '0;
            bus.i_nx_rdata = '0;
            rx_drop = 1'b0;
            rx_gap = 0;
            nx_busy_cnt = 0;
            tx_busy_cnt = 0;
            bus.i_nx_busy = force_nx;
            bus.i_tx_busy = force_tx;
        end else begin
            if (bus.o_rx_ack) begin
                ack_cyc.push_back(cyc);
                chk("rx_ack_needs_rdy", 32'(bus.i_rx_rdy), 32'd1);
                rx_drop = 1'b1;
            end else if (rx_drop) begin
                bus.i_rx_rdy = 1'b0;
                rx_drop = 1'b0;
                rx_gap = $urandom_range(0, 3);
            end else if (!bus.i_rx_rdy && rx_q.size() > 0) begin
                if (rx_gap > 0) rx_gap--;
                else begin
                    bus.i_rx_data = rx_q.pop_front();
                    bus.i_rx_rdy  = 1'b1;
                end
            end

            if (bus.o_nx_start) begin
                nx_cyc.push_back(cyc);
                log_addr.push_back(bus.o_nx_addr);
                chk("nx_start_while_busy", 32'(bus.i_nx_busy), 32'd0);
                chk("nx_start_expected", 32'(exp_nx.size() > 0), 32'd1);
                if (exp_nx.size() > 0) begin
                    e = exp_nx.pop_front();
                    chk("nx_addr", 32'(bus.o_nx_addr), 32'(e.addr));
                    chk("nx_wr", 32'(bus.o_nx_wr), 32'(e.wr));
                    if (e.wr) chk("nx_wdata", 32'(bus.o_nx_wdata), 32'(e.wdata));
                end
                if (bus.o_nx_wr) sd_mem[bus.o_nx_addr] = bus.o_nx_wdata;
                else bus.i_nx_rdata = sd_mem[bus.o_nx_addr];
                nx_busy_cnt = $urandom_range(1, 6);
            end else if (nx_busy_cnt > 0) begin
                nx_busy_cnt--;
            end
            bus.i_nx_busy = force_nx || (nx_busy_cnt > 0);

            if (bus.o_tx_start) begin
                log_tx.push_back(bus.o_tx_data);
                chk("tx_start_while_busy", 32'(bus.i_tx_busy), 32'd0);
                chk("tx_byte_expected", 32'(exp_tx.size() > 0), 32'd1);
                if (exp_tx.size() > 0) chk("tx_byte", 32'(bus.o_tx_data), 32'(exp_tx.pop_front()));
                tx_busy_cnt = $urandom_range(1, 8);
            end else if (tx_busy_cnt > 0) begin
                tx_busy_cnt--;
            end
            bus.i_tx_busy = force_tx || (tx_busy_cnt > 0);
        end
    end

    // Reference model: what one command must do to the serdes and the tx stream
    task automatic model_cmd(input logic w, input logic [6:0] a, input logic inc,
                             input int unsigned len, input logic [DW-1:0] words[$]);
        logic [6:0] ad;
        nx_t t;
        ad = a;
        for (int unsigned i = 0; i < len; i++) begin
            t.addr = ad;
            t.wr = w;
            t.wdata = w ? words[i] : '0;
            exp_nx.push_back(t);
            if (w) ref_mem[ad] = words[i];
            else for (int b = DB - 1; b >= 0; b--) exp_tx.push_back(ref_mem[ad][8*b +: 8]);
            if (inc) ad = ad + 7'd1;
        end
    endtask

    task automatic issue_cmd(input logic w, input logic [6:0] a, input logic inc,
                             input int unsigned len, input logic [DW-1:0] words[$]);
        rx_q.push_back({w, a});
        rx_q.push_back({inc, 7'(len - 1)});
        if (w) foreach (words[i]) for (int b = DB - 1; b >= 0; b--) rx_q.push_back(words[i][8*b +: 8]);
        model_cmd(w, a, inc, len, words);
    endtask

    task automatic issue_rand(input logic w, input logic [6:0] a, input logic inc, input int unsigned len);
        logic [DW-1:0] words[$];
        for (int unsigned i = 0; i < len; i++) words.push_back(DW'($urandom));
        issue_cmd(w, a, inc, len, words);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((exp_nx.size() > 0 || exp_tx.size() > 0 || rx_q.size() > 0 ||
                bus.i_rx_rdy || bus.o_active) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", tag}, 32'(n < 30000), 32'd1);
        chk({"idle_", tag}, 32'(bus.o_active), 32'd0);
    endtask

    function automatic int unsigned cur(input int sel);
        if (sel == SEL_TX) return log_tx.size();
        if (sel == SEL_NX) return log_addr.size();
        return ack_cyc.size();
    endfunction

    task automatic wait_for(input int sel, input int unsigned target, input string tag);
        int unsigned k = 0;
        while (cur(sel) < target && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < 5000), 32'd1);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_rx_ack"},   32'(bus.o_rx_ack),   32'd0);
        chk({tag, "_tx_start"}, 32'(bus.o_tx_start), 32'd0);
        chk({tag, "_tx_data"},  32'(bus.o_tx_data),  32'd0);
        chk({tag, "_nx_start"}, 32'(bus.o_nx_start), 32'd0);
        chk({tag, "_nx_addr"},  32'(bus.o_nx_addr),  32'd0);
        chk({tag, "_nx_wr"},    32'(bus.o_nx_wr),    32'd0);
        chk({tag, "_nx_wdata"}, 32'(bus.o_nx_wdata), 32'd0);
        chk({tag, "_active"},   32'(bus.o_active),   32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        rx_q.delete();
        #1 outputs_zero("rst_async");
        repeat (3) @(negedge clk);
        chk("rst_held_active", 32'(bus.o_active), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] words[$];
        int unsigned n0, a0, diffs;
        for (int i = 0; i < 128; i++) begin
            sd_mem[i] = DW'($urandom);
            ref_mem[i] = sd_mem[i];
        end
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single read with 1-cycle issue latency
        sd_mem[5] = 16'hBEEF;
        ref_mem[5] = 16'hBEEF;
        log_tx.delete(); log_addr.delete(); ack_cyc.delete(); nx_cyc.delete();
        issue_rand(1'b0, 7'h05, 1'b0, 1);
        chk("model_tx0", 32'(exp_tx[0]), 32'hBE);
        chk("model_tx1", 32'(exp_tx[1]), 32'hEF);
        drain("single_read");
        chk("sr_nx_count", log_addr.size(), 32'd1);
        chk("sr_addr", 32'(log_addr[0]), 32'h05);
        chk("sr_tx0", 32'(log_tx[0]), 32'hBE);
        chk("sr_tx1", 32'(log_tx[1]), 32'hEF);
        chk("sr_latency", nx_cyc[0] - ack_cyc[1], 32'd1);

        // Incrementing write burst
        words = '{16'h1234, 16'h5678, 16'h9ABC};
        issue_cmd(1'b1, 7'h10, 1'b1, 3, words);
        drain("write_burst");
        chk("wb_mem10", 32'(sd_mem[7'h10]), 32'h1234);
        chk("wb_mem11", 32'(sd_mem[7'h11]), 32'h5678);
        chk("wb_mem12", 32'(sd_mem[7'h12]), 32'h9ABC);

        // Address wrap and hold
        log_addr.delete();
        issue_rand(1'b0, 7'h7F, 1'b1, 2);
        drain("wrap");
        chk("wrap_a0", 32'(log_addr[0]), 32'h7F);
        chk("wrap_a1", 32'(log_addr[1]), 32'h00);
        log_addr.delete();
        issue_rand(1'b0, 7'h7F, 1'b0, 2);
        drain("hold");
        chk("hold_a0", 32'(log_addr[0]), 32'h7F);
        chk("hold_a1", 32'(log_addr[1]), 32'h7F);

        // Back-pressure on tx and serdes, with a header byte pending mid-burst
        log_addr.delete(); log_tx.delete();
        issue_rand(1'b0, 7'h30, 1'b1, 6);
        wait_for(SEL_TX, 1, "bp_first_tx");
        force_tx = 1'b1;
        issue_rand(1'b0, 7'h40, 1'b0, 1);
        repeat (2) @(negedge clk);
        n0 = log_tx.size();
        a0 = ack_cyc.size();
        repeat (998) @(negedge clk);
        chk("bp_tx_held", log_tx.size() - n0, 32'd0);
        chk("bp_rx_pending", ack_cyc.size() - a0, 32'd0);
        force_tx = 1'b0;
        wait_for(SEL_NX, log_addr.size() + 1, "bp_next_nx");
        force_nx = 1'b1;
        repeat (2) @(negedge clk);
        n0 = log_addr.size();
        repeat (498) @(negedge clk);
        chk("bp_nx_held", log_addr.size() - n0, 32'd0);
        force_nx = 1'b0;
        drain("backpressure");
        chk("bp_nx_count", log_addr.size(), 32'd7);
        chk("bp_last_addr", 32'(log_addr[6]), 32'h40);
        chk("bp_tx_count", log_tx.size(), 32'd14);

        // Randomized bursts, then long bursts crossing the address wrap
        for (int i = 0; i < 24; i++) begin
            issue_rand(1'($urandom), 7'($urandom), 1'($urandom), $urandom_range(1, 8));
            drain("rand");
        end
        issue_rand(1'b1, 7'h70, 1'b1, 128);
        drain("long_write");
        issue_rand(1'b0, 7'h70, 1'b1, 128);
        drain("long_read");

        // Reset mid write payload (1 of 2 bytes received)
        a0 = ack_cyc.size();
        rx_q.push_back(8'h90); rx_q.push_back(8'h00); rx_q.push_back(8'h12);
        wait_for(SEL_ACK, a0 + 3, "rst_acks");
        repeat (2) @(negedge clk);
        chk("rst_pre_active", 32'(bus.o_active), 32'd1);
        pulse_reset();
        repeat (2) @(negedge clk);
        log_addr.delete();
        issue_rand(1'b0, 7'h22, 1'b0, 1);
        drain("after_reset");
        chk("after_reset_addr", 32'(log_addr[0]), 32'h22);

        // Stalled write payload: timeout (if built in) or indefinite wait
        n0 = log_addr.size();
        a0 = ack_cyc.size();
        rx_q.push_back(8'h85); rx_q.push_back(8'h00); rx_q.push_back(8'h12);
        wait_for(SEL_ACK, a0 + 3, "to_acks");
        repeat (150) @(negedge clk);
        chk("to_no_nx", log_addr.size() - n0, 32'd0);
`ifdef BRIDGE_TIMEOUT_EN
        chk("to_back_to_cmd", 32'(bus.o_active), 32'd0);
`else
        chk("to_still_waiting", 32'(bus.o_active), 32'd1);
        pulse_reset();
        repeat (2) @(negedge clk);
`endif
        issue_rand(1'b0, 7'h05, 1'b1, 2);
        drain("after_timeout");

        diffs = 0;
        for (int i = 0; i < 128; i++) if (sd_mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", diffs, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
